// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and widths for the memory arbiter
package core_pkg;
  localparam int XLEN = 32;
  localparam int BE_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;
  typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_t;
endpackage

// File: rtl/arb_wdog.sv
// rtl/arb_wdog.sv - loadable, clearable up-counter with terminal-count compare
module arb_wdog #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare the registered count so the tc output never depends on clr.
  assign tc = (cnt_q == tc_val);
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding fetch/data arbiter for one memory bus
module mem_arbiter
  import core_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_valid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [BE_W-1:0] d_be,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_valid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [BE_W-1:0] mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            err,
  output logic            err_src
);
  localparam int              WD_W       = 16;
  localparam logic [WD_W-1:0] WD_TC      = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);
  localparam logic [7:0]      STREAK_MAX = 8'(MAX_DSTREAK);

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  logic [7:0] streak_q, streak_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [BE_W-1:0] mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic err_q, err_d, err_src_q, err_src_d;
  logic grant_data, finish, wd_tc, wd_fire, wd_en, wd_clr;
  logic [XLEN-1:0] fin_data;

  assign wd_en   = (state_q == S_REQ) || (state_q == S_RESP);
  assign wd_clr  = (state_d != state_q);
  assign wd_fire = (TIMEOUT != 0) && wd_tc;

  arb_wdog #(.W(WD_W)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (wd_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (wd_en),
    .tc_val   (WD_TC),
    .tc       (wd_tc)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    err_src_d   = err_src_q;
    finish      = 1'b0;
    fin_data    = '0;
    // Fetch wins a contested grant only once data has used up its streak.
    grant_data  = d_req && !(if_req && (streak_q == STREAK_MAX));

    unique case (state_q)
      S_IDLE: begin
        if (d_req || if_req) begin
          state_d     = S_REQ;
          owner_d     = grant_data ? OWN_DATA : OWN_FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = grant_data ? d_we : 1'b0;
          mem_be_d    = grant_data ? d_be : {BE_W{1'b1}};
          mem_addr_d  = grant_data ? d_addr : if_addr;
          mem_wdata_d = grant_data ? d_wdata : '0;
          if (grant_data && if_req) begin
            streak_d = (streak_q < STREAK_MAX) ? streak_q + 8'd1 : streak_q;
          end else begin
            streak_d = '0;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
        end else if (wd_fire) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          err_src_d = owner_q;
          finish    = 1'b1;
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          finish   = 1'b1;
          fin_data = mem_we_q ? '0 : mem_rdata;
        end else if (wd_fire) begin
          err_d     = 1'b1;
          err_src_d = owner_q;
          finish    = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d = S_DONE;
      if (owner_q == OWN_DATA) begin
        d_valid_d = 1'b1;
        d_rdata_d = fin_data;
      end else begin
        if_valid_d = 1'b1;
        if_rdata_d = fin_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_FETCH;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
      err_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      err_src_q   <= err_src_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign err_src   = err_src_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - table-driven scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  localparam int TO = 8;

  logic clk, rst;
  logic if_req, if_valid, d_req, d_we, d_valid;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0] d_be, mem_be;
  logic mem_req, mem_we, mem_gnt, mem_rvalid, err, err_src;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err(err), .err_src(err_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt_dly;
    int          rv_dly;
    logic        no_gnt;
    logic        rv_in_req;
    logic [31:0] bus_rdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_nreq;
    logic        exp_err;
    logic        exp_src;
  } txn_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbq[$];
  txn_t tbl[8];
  int n_tests = 0;
  int n_fail  = 0;

  int b_gnt_dly, b_rv_dly, b_state, b_req_cnt, b_rv_cnt;
  logic b_no_gnt, b_rv_in_req, b_from_addr;
  logic [31:0] b_rdata, b_gaddr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic is_d, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int gd, input int rd, input logic ng, input logic rir,
                              input logic [31:0] brd, input logic [31:0] erd,
                              input int lat, input int nreq, input logic e_err, input logic e_src);
    txn_t t;
    t.is_d = is_d; t.we = we; t.be = be; t.addr = addr; t.wdata = wdata;
    t.gnt_dly = gd; t.rv_dly = rd; t.no_gnt = ng; t.rv_in_req = rir;
    t.bus_rdata = brd; t.exp_rdata = erd; t.exp_lat = lat; t.exp_nreq = nreq;
    t.exp_err = e_err; t.exp_src = e_src;
    return t;
  endfunction

  // One negedge of the memory-side responder; rv_dly < 0 means never respond.
  task automatic bus_step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'hBAD0_0BAD;
    if (b_state == 0) begin
      if (mem_req) begin
        b_req_cnt++;
        if (!b_no_gnt && b_req_cnt == b_gnt_dly + 1) begin
          mem_gnt = 1'b1;
          b_state = 1;
          b_rv_cnt = 0;
          b_gaddr = mem_addr;
        end else if (b_rv_in_req) begin
          mem_rvalid = 1'b1;
        end
      end else begin
        b_req_cnt = 0;
      end
    end else begin
      if (b_rv_cnt == b_rv_dly) begin
        mem_rvalid = 1'b1;
        mem_rdata = b_from_addr ? (b_gaddr ^ 32'h5A5A_0000) : b_rdata;
        b_state = 0;
        b_req_cnt = 0;
      end else begin
        b_rv_cnt++;
      end
    end
  endtask

  task automatic run_txn(input txn_t t, input string tag);
    int lat, nreq;
    bit seen;
    exp_t e;
    b_state = 0; b_req_cnt = 0; b_rv_cnt = 0;
    b_gnt_dly = t.gnt_dly; b_rv_dly = t.rv_dly; b_no_gnt = t.no_gnt;
    b_rv_in_req = t.rv_in_req; b_rdata = t.bus_rdata; b_from_addr = 1'b0;
    if (t.is_d) begin
      d_req = 1'b1; d_we = t.we; d_be = t.be; d_addr = t.addr; d_wdata = t.wdata;
    end else begin
      if_req = 1'b1; if_addr = t.addr;
    end
    e.is_d = t.is_d;
    e.rdata = t.exp_rdata;
    sbq.push_back(e);
    lat = 0; nreq = 0; seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (mem_req) begin
        nreq++;
        check({tag, "_addr"}, mem_addr, t.addr);
        check({tag, "_ctl"}, {mem_we, mem_be, mem_wdata},
              t.is_d ? {t.we, t.be, t.wdata} : {1'b0, 4'hF, 32'h0});
      end
      if (if_valid || d_valid) seen = 1;
      bus_step();
    end
    check({tag, "_seen"}, seen, 1);
    check({tag, "_lat"}, lat, t.exp_lat);
    check({tag, "_nreq"}, nreq, t.exp_nreq);
    check({tag, "_err"}, {err, err_src}, {t.exp_err, t.exp_src});
    if_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (if_valid || d_valid)) begin
        exp_t e;
        if (if_valid && d_valid) check("both_valid", 1, 0);
        if (sbq.size() == 0) begin
          check("unexpected_valid", {if_valid, d_valid}, 0);
        end else begin
          e = sbq.pop_front();
          check("valid_owner", d_valid, e.is_d);
          check("valid_rdata", d_valid ? d_rdata : if_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    int nv;
    rst = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    b_state = 0; b_req_cnt = 0; b_rv_cnt = 0; b_gnt_dly = 0; b_rv_dly = 0;
    b_no_gnt = 0; b_rv_in_req = 0; b_from_addr = 0; b_rdata = 0; b_gaddr = 0;

    tbl[0] = mk(0, 0, 4'hF,    32'h100,  32'h0,         0,  0, 0, 0, 32'h00500093, 32'h00500093,  3, 1, 0, 0);
    tbl[1] = mk(1, 1, 4'b0011, 32'h2004, 32'hDEAD_BEEF, 3,  0, 0, 0, 32'h12345678, 32'h0,         6, 4, 0, 0);
    tbl[2] = mk(1, 0, 4'hF,    32'h2008, 32'h0,         1,  2, 0, 1, 32'hCAFEF00D, 32'hCAFEF00D,  6, 2, 0, 0);
    tbl[3] = mk(0, 0, 4'hF,    32'h3,    32'h0,         0,  5, 0, 0, 32'h11112222, 32'h11112222,  8, 1, 0, 0);
    tbl[4] = mk(1, 0, 4'b0100, 32'h2010, 32'h0,         7,  7, 0, 0, 32'h0BADC0DE, 32'h0BADC0DE, 17, 8, 0, 0);
    tbl[5] = mk(0, 0, 4'hF,    32'h108,  32'h0,         0, -1, 0, 0, 32'h77777777, 32'h0,        10, 1, 1, 0);
    tbl[6] = mk(1, 0, 4'hF,    32'h2020, 32'h0,         0,  0, 1, 0, 32'h88888888, 32'h0,         9, 8, 1, 1);
    tbl[7] = mk(0, 0, 4'hF,    32'h104,  32'h0,         0,  0, 0, 0, 32'h00A00113, 32'h00A00113,  3, 1, 1, 1);

    repeat (2) @(negedge clk);
    check("rst_ctl", {mem_req, mem_we, mem_be, if_valid, d_valid, err, err_src}, 0);
    check("rst_bus", {mem_addr, mem_wdata}, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_req", mem_req, 0);

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("t%0d", i));

    // Reset while the bus owes a response; a late rvalid must be ignored.
    b_state = 0; b_req_cnt = 0; b_gnt_dly = 0; b_rv_dly = -1; b_no_gnt = 0; b_rv_in_req = 0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h2040;
    @(negedge clk); bus_step();
    @(negedge clk); bus_step();
    rst = 1'b1;
    #1;
    check("midrst_ctl", {mem_req, mem_we, mem_be, if_valid, d_valid, err, err_src}, 0);
    check("midrst_addr", mem_addr, 0);
    check("midrst_rdata", {if_rdata, d_rdata}, 0);
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("late_rvalid", {mem_req, if_valid, d_valid, err}, 0);
    end
    run_txn(mk(0, 0, 4'hF, 32'h200, 32'h0, 0, 0, 0, 0, 32'h13, 32'h13, 3, 1, 0, 0), "post_rst");

    // Fairness: both requesters busy, data may win at most four in a row.
    b_state = 0; b_req_cnt = 0; b_gnt_dly = 0; b_rv_dly = 0; b_no_gnt = 0;
    b_rv_in_req = 0; b_from_addr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      e.is_d = (i % 5) != 4;
      e.rdata = (e.is_d ? 32'h2000 : 32'h1000) ^ 32'h5A5A_0000;
      sbq.push_back(e);
    end
    if_req = 1'b1; if_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h2000;
    nv = 0;
    for (int c = 0; c < 200 && nv < 10; c++) begin
      @(negedge clk);
      if (if_valid || d_valid) nv++;
      if (nv == 10) begin
        if_req = 1'b0;
        d_req = 1'b0;
      end
      bus_step();
    end
    check("fair_count", nv, 10);
    repeat (3) @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    check("fair_no_req", mem_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
